// File: rtl/counter_access_arbiter.sv
// Round-robin arbiter that shares one saturating up/down counter between NUM_REQ requesters.
// Define CNT_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module counter_access_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_dir,
  input  logic [WIDTH-1:0]   count_in,
  output logic               cnt_inc,
  output logic               cnt_dec,
  output logic [NUM_REQ-1:0] req_ack,
  output logic               req_err,
  output logic               busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic               refused_q, refused_d;
  logic               cnt_inc_q, cnt_inc_d;
  logic               cnt_dec_q, cnt_dec_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic               req_err_q, req_err_d;
  logic               busy_q, busy_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               win_dir;
  logic               win_refused;
  logic [IDX_W-1:0]   search_base;

  assign search_base = rr_ptr_q;

  // First valid requester at or above search_base, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      int unsigned pos;
      pos = (32'(search_base) + i) % NUM_REQ;
      if (!win_found && req_valid[IDX_W'(pos)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(pos);
      end
    end
  end

  assign win_dir     = req_dir[win_idx];
  assign win_refused = win_dir ? (count_in == COUNT_MAX) : (count_in == '0);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    winner_d  = winner_q;
    refused_d = refused_q;
    cnt_inc_d = 1'b0;
    cnt_dec_d = 1'b0;
    req_ack_d = '0;
    req_err_d = 1'b0;
    busy_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d   = ISSUE;
          busy_d    = 1'b1;
          winner_d  = win_idx;
          refused_d = win_refused;
          cnt_inc_d = win_dir & ~win_refused;
          cnt_dec_d = ~win_dir & ~win_refused;
`ifdef CNT_ARB_FIXED_PRIO_EN
          rr_ptr_d  = '0;
`else
          rr_ptr_d  = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
`endif
        end
      end
      ISSUE: begin
        state_d   = SETTLE;
        busy_d    = 1'b1;
        req_ack_d = NUM_REQ'(1) << winner_q;
        req_err_d = refused_q;
      end
      SETTLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Synchronous reset aborts any in-flight operation without an ack.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      winner_q  <= '0;
      refused_q <= 1'b0;
      cnt_inc_q <= 1'b0;
      cnt_dec_q <= 1'b0;
      req_ack_q <= '0;
      req_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      winner_q  <= winner_d;
      refused_q <= refused_d;
      cnt_inc_q <= cnt_inc_d;
      cnt_dec_q <= cnt_dec_d;
      req_ack_q <= req_ack_d;
      req_err_q <= req_err_d;
      busy_q    <= busy_d;
    end
  end

  assign cnt_inc = cnt_inc_q;
  assign cnt_dec = cnt_dec_q;
  assign req_ack = req_ack_q;
  assign req_err = req_err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_counter_access_arbiter.sv
// Directed bench for counter_access_arbiter: table of single operations plus multi-cycle sequences.
// Expected grant order follows the build selected by CNT_ARB_FIXED_PRIO_EN.
module tb_counter_access_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req_valid;
  logic [3:0] req_dir;
  logic [3:0] count_in;
  logic       cnt_inc;
  logic       cnt_dec;
  logic [3:0] req_ack;
  logic       req_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit model_en = 1'b0;
  bit auto_clr = 1'b0;

  counter_access_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_dir   (req_dir),
    .count_in  (count_in),
    .cnt_inc   (cnt_inc),
    .cnt_dec   (cnt_dec),
    .req_ack   (req_ack),
    .req_err   (req_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cnt;
    logic [3:0] valid;
    logic [3:0] dir;
    logic [3:0] ack_rr;
    logic [3:0] ack_fp;
    logic       inc;
    logic       dec;
    logic       err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one cycle, sample after the edge, apply counter and requester models.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("inc_dec_exclusive", {31'd0, cnt_inc & cnt_dec}, 32'd0);
    if (model_en) begin
      if (cnt_inc) count_in = count_in + 4'd1;
      else if (cnt_dec) count_in = count_in - 4'd1;
    end
    if (auto_clr) req_valid = req_valid & ~req_ack;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Post a request, wait (bounded) for its ack, then return to IDLE with no requests pending.
  task automatic run_op(input logic [3:0] valid, input logic [3:0] dir,
                        output logic [3:0] ack, output logic err);
    int n;
    req_valid = valid;
    req_dir   = dir;
    ack = '0;
    err = 1'b0;
    n = 0;
    while (req_ack == 4'd0 && n < 10) begin
      tick();
      n++;
    end
    if (req_ack == 4'd0) chk("ack_timeout", 32'd0, 32'd1);
    ack = req_ack;
    err = req_err;
    tick();
    req_valid = '0;
  endtask

  logic [3:0] ack_l;
  logic       err_l;
  int         ack_cyc[$];
  logic [3:0] ack_seq[$];

  initial begin
    vecs[0] = '{4'd5,  4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{4'd15, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{4'd0,  4'b0010, 4'b0000, 4'b0010, 4'b0010, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{4'd8,  4'b1010, 4'b0000, 4'b1000, 4'b0010, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{4'd3,  4'b0110, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{4'd15, 4'b0101, 4'b0000, 4'b0100, 4'b0001, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{4'd0,  4'b0011, 4'b0011, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{4'd15, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b1, 1'b0};

    req_valid = '0;
    req_dir   = '0;
    count_in  = 4'd5;
    do_reset();
    chk("rst_outputs", {27'd0, cnt_inc, cnt_dec, req_err, busy, |req_ack}, 32'd0);

    // Table: one operation per vector, request dropped once latched.
    for (int v = 0; v < 8; v++) begin
      logic [3:0] exp_ack;
`ifdef CNT_ARB_FIXED_PRIO_EN
      exp_ack = vecs[v].ack_fp;
`else
      exp_ack = vecs[v].ack_rr;
`endif
      count_in  = vecs[v].cnt;
      req_valid = vecs[v].valid;
      req_dir   = vecs[v].dir;
      tick();
      chk($sformatf("v%0d_issue", v), {28'd0, busy, cnt_inc, cnt_dec, |req_ack},
          {28'd0, 1'b1, vecs[v].inc, vecs[v].dec, 1'b0});
      req_valid = '0;
      tick();
      chk($sformatf("v%0d_settle", v), {22'd0, busy, cnt_inc, cnt_dec, req_err, 4'd0, req_ack},
          {22'd0, 1'b1, 1'b0, 1'b0, vecs[v].err, 4'd0, exp_ack});
      tick();
      chk($sformatf("v%0d_idle", v), {27'd0, busy, cnt_inc, cnt_dec, req_err, |req_ack}, 32'd0);
    end

    // All four requesters held valid, each dropping on its own ack.
    do_reset();
    model_en  = 1'b1;
    auto_clr  = 1'b1;
    count_in  = 4'd5;
    req_dir   = 4'b1111;
    req_valid = 4'b1111;
    for (int n = 0; n < 30 && ack_seq.size() < 4; n++) begin
      tick();
      if (req_ack != 4'd0) begin
        ack_seq.push_back(req_ack);
        ack_cyc.push_back(cyc);
      end
    end
    chk("all_valid_ack_count", ack_seq.size(), 32'd4);
    for (int k = 0; k < ack_seq.size(); k++) begin
      chk($sformatf("all_valid_order%0d", k), {28'd0, ack_seq[k]}, 32'd1 << k);
      if (k > 0) chk($sformatf("all_valid_gap%0d", k), ack_cyc[k] - ack_cyc[k-1], 32'd3);
    end
    tick();
    chk("all_valid_count", {28'd0, count_in}, 32'd9);
    chk("all_valid_drained", {28'd0, req_valid}, 32'd0);

    run_op(4'b0101, 4'b0101, ack_l, err_l);
    chk("reraise_ack", {27'd0, err_l, ack_l}, {27'd0, 1'b0, 4'b0001});

    // Alternating increment (req 1) and decrement (req 3) around 7.
    count_in = 4'd7;
    for (int r = 0; r < 3; r++) begin
      run_op(4'b0010, 4'b0010, ack_l, err_l);
      chk($sformatf("alt%0d_inc_ack", r), {27'd0, err_l, ack_l}, {27'd0, 1'b0, 4'b0010});
      chk($sformatf("alt%0d_count8", r), {28'd0, count_in}, 32'd8);
      run_op(4'b1000, 4'b0000, ack_l, err_l);
      chk($sformatf("alt%0d_dec_ack", r), {27'd0, err_l, ack_l}, {27'd0, 1'b0, 4'b1000});
      chk($sformatf("alt%0d_count7", r), {28'd0, count_in}, 32'd7);
    end

    // Reset during ISSUE: no ack, outputs cleared, pointer back to 0.
    auto_clr  = 1'b0;
    do_reset();
    count_in  = 4'd5;
    req_dir   = 4'b0100;
    req_valid = 4'b0100;
    tick();
    chk("rst_mid_issue_inc", {31'd0, cnt_inc}, 32'd1);
    reset_n   = 1'b0;
    req_valid = '0;
    tick();
    chk("rst_mid_outputs", {27'd0, cnt_inc, cnt_dec, req_err, busy, |req_ack}, 32'd0);
    reset_n   = 1'b1;
    req_dir   = 4'b0010;
    req_valid = 4'b1010;
    tick();
    chk("post_rst_issue", {29'd0, busy, cnt_inc, cnt_dec}, {29'd0, 3'b110});
    req_valid = '0;
    tick();
    chk("post_rst_ack", {27'd0, req_err, req_ack}, {27'd0, 1'b0, 4'b0010});
    tick();
    chk("post_rst_count", {28'd0, count_in}, 32'd7);
    chk("post_rst_idle", {30'd0, busy, |req_ack}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_access_arbiter.md
Name: counter_access_arbiter

Overview:
- Shares one up/down counter (the existing 4-bit increment/decrement counter) between NUM_REQ requesters.
- Each requester posts an increment or decrement request with a valid/ack handshake.
- Block arbitrates round-robin, issues exactly one single-cycle increment or decrement pulse per granted request, and refuses operations that would wrap the counter.
- Sits directly in front of the counter; owns its increment/decrement inputs and observes its count output.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 4, counter width; COUNT_MAX = 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset; sampled on rising clk edge.
- req_valid  input  NUM_REQ  per-requester request; held high until its ack.
- req_dir  input  NUM_REQ  per-requester direction: 1 = increment, 0 = decrement; stable while req_valid high.
- count_in  input  WIDTH  current counter value (counter's count output).
- cnt_inc  output  1  increment pulse to counter.
- cnt_dec  output  1  decrement pulse to counter.
- req_ack  output  NUM_REQ  one-hot, one-cycle completion pulse.
- req_err  output  1  valid with req_ack; 1 = operation refused (saturation).
- busy  output  1  high in ISSUE and SETTLE.

Behaviour:
- All outputs registered.
- reset_n low at an edge forces: state IDLE, cnt_inc=0, cnt_dec=0, req_ack=0, req_err=0, busy=0, rr_ptr=0, latched winner/dir cleared. Applies mid-operation: any in-flight op is aborted with no ack; a pulse already issued is not undone.
- FSM states: IDLE, ISSUE, SETTLE.
- IDLE:
  - If any req_valid, select the winner: first set bit searching from rr_ptr upward, modulo NUM_REQ.
  - Latch winner index and req_dir[winner].
  - Evaluate refusal against count_in this cycle: increment refused if count_in==COUNT_MAX; decrement refused if count_in==0.
  - Next edge: state=ISSUE, busy=1, rr_ptr=(winner+1) mod NUM_REQ.
  - cnt_inc = dir & ~refused; cnt_dec = ~dir & ~refused.
  - If no req_valid, stay in IDLE with all outputs 0.
- ISSUE (one cycle): cnt_inc/cnt_dec high this cycle only; counter updates at the end of this cycle. Next edge: state=SETTLE, cnt_inc=cnt_dec=0, req_ack[winner]=1, req_err=refused.
- SETTLE (one cycle):
  - req_ack/req_err visible and count_in already reflects the operation.
  - Next edge: state=IDLE, req_ack=0, req_err=0, busy=0.
  - Requester deasserts req_valid on the edge at which it samples req_ack, so IDLE never re-grants a completed request.
- Latency: valid sampled in cycle T → pulse in T+1 → ack in T+2 → IDLE in T+3. Throughput is one op per 3 cycles.
- Never asserts cnt_inc and cnt_dec together; at most one pulse per ack.
- req_valid dropped after being latched: op still completes and ack still pulses.
- req_valid changes outside IDLE: ignored; arbitration only in IDLE.
- Refused op: no counter pulse, full ISSUE/SETTLE sequence, req_err=1, rr_ptr still advances.
- Single requester continuously valid: served every 3 cycles.
- All valid: grant order rr_ptr, rr_ptr+1, …; no starvation; each requester waits ≤ 3·NUM_REQ cycles.

Optional Feature:
- Macro: CNT_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr removed (held 0).
- Undefined: round-robin as above.
- All timing, handshake and saturation rules are identical in both builds.

Test Plan:
- Reset with count_in=5: req_valid=0001, dir=1 → cnt_inc high exactly at T+1, req_ack=0001 at T+2, req_err=0, busy high for T+1..T+2.
- count_in=15, requester 2 requests increment → no cnt_inc/cnt_dec pulse, req_ack=0100 with req_err=1. Repeat with count_in=0 and a decrement → same refusal.
- req_valid=1111 held continuously, each requester deasserting on its own ack → acks in order 0,1,2,3, each 3 cycles apart; the fixed-prio build gives 0,1,2,3 only as each drops, and 0 again if re-raised.
- Requester 1 increment and requester 3 decrement alternately from count_in=7 with the counter model attached → count returns to 7; cnt_inc and cnt_dec never both high.
- reset_n low during ISSUE → no req_ack that operation; all outputs 0 at the next edge; rr_ptr=0; the next grant goes to the lowest valid index.
